r_seq_ctrl: RTL

//  Multi-cycle sequencer for the R-type datapath: fetches a 32-bit word over a req/ack bus, decodes OP/func

---
 rtl/r_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/r_seq_ctrl.sv
// r_seq_ctrl: fetch/decode/exec/writeback sequencer for R-type instructions (macro RSEQ_SINGLE_STEP_EN adds step input).
// Latency: ack cycle + DECODE + EXEC + WB = 4 cycles per instruction with zero-wait instruction memory.
// Backpressure: imem_req held until imem_ack; TIMEOUT_CYC unacknowledged FETCH cycles raise bus_err and halt.
module r_seq_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef RSEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             ir_we,
    output logic [2:0]       alu_op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int            TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   ir;
    logic [TW-1:0] tcnt;
    logic          dec_ok;
    logic [2:0]    dec_op;
    logic          start;
    logic          wb_cont;
    logic          timeout_hit;
    logic          unused_shamt;

    // Shift amount is not part of the R-type control decode.
    assign unused_shamt = ^ir[10:6];

`ifdef RSEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_pend;
    logic step_rise;
    logic unused_run;

    assign unused_run = run;
    assign step_rise  = step & ~step_q;
    // An edge seen mid-instruction is held until the sequencer parks in IDLE.
    assign start      = step_rise | step_pend;
    assign wb_cont    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (state == S_IDLE)
                step_pend <= 1'b0;
            else if (step_rise)
                step_pend <= 1'b1;
        end
    end
`else
    assign start   = run;
    assign wb_cont = run;
`endif

    assign timeout_hit = (state == S_FETCH) && !imem_ack && (tcnt == TLAST);

    always_comb begin
        dec_ok = 1'b1;
        dec_op = 3'b000;
        if (ir[31:26] != 6'd0) begin
            dec_ok = 1'b0;
        end else begin
            case (ir[5:0])
                6'b100000: dec_op = 3'b100;
                6'b100010: dec_op = 3'b101;
                6'b100100: dec_op = 3'b000;
                6'b100101: dec_op = 3'b001;
                6'b100110: dec_op = 3'b010;
                6'b100111: dec_op = 3'b011;
                6'b101011: dec_op = 3'b110;
                6'b000100: dec_op = 3'b111;
                default:   dec_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)
                    state_nx = S_DECODE;
                else if (timeout_hit)
                    state_nx = S_HALT;
            end
            S_DECODE: state_nx = dec_ok ? S_EXEC : S_FETCH;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = wb_cont ? S_FETCH : S_IDLE;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == S_FETCH);
        ir_we    = (state == S_FETCH) && imem_ack;
        rf_we    = (state == S_WB) && (rd != 5'd0);
        pc_we    = (state == S_WB) || ((state == S_DECODE) && !dec_ok);
        busy     = (state != S_IDLE) && (state != S_HALT);
    end

    // Counts consecutive unacknowledged FETCH cycles; cleared everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if ((state == S_FETCH) && !imem_ack)
            tcnt <= tcnt + 1'b1;
        else
            tcnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            alu_op  <= 3'b000;
            rs      <= 5'd0;
            rt      <= 5'd0;
            rd      <= 5'd0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            if (ir_we)
                ir <= imem_rdata;
            if (state == S_DECODE) begin
                rs <= ir[25:21];
                rt <= ir[20:16];
                rd <= ir[15:11];
                if (dec_ok)
                    alu_op <= dec_op;
                else
                    illegal <= 1'b1;
            end
            if (timeout_hit)
                bus_err <= 1'b1;
            if (state == S_WB)
                retired <= retired + 1'b1;
        end
    end

endmodule
